addr_gen: RTL and testbench
===========================

ADDR_GEN -- requirements
Module: addr_gen

Interface
REQ-001 The block SHALL generate a two-level strided address stream that drives addr0 of the neighbouring Mem unit; all data-path widths SHALL be 32 bits.
REQ-002 Parameter BASE, default 0: first address of every pass.
REQ-003 Parameter STRIDE, default 1: inner-loop increment, 32-bit two's complement.
REQ-004 Parameter INNER, default 4: addresses per row; 0 SHALL be treated as 1.
REQ-005 Parameter OUTER_STRIDE, default 0: row-to-row increment applied to the row base, 32-bit two's complement.
REQ-006 Parameter OUTER, default 1: rows per pass; 0 SHALL be treated as 1.
REQ-007 Parameter REPEAT, default 0: 1 = restart at BASE after the last address instead of finishing.
REQ-008 clk  input  1  single clock; all state changes on the rising edge.
REQ-009 rst  input  1  reset, asynchronous and active-high.
REQ-010 start  input  1  begin a pass; sampled only in IDLE.
REQ-011 en  input  1  consumer accepts the current address when en=1 and valid=1; en=0 stalls.
REQ-012 addr_out  output  32  current address.
REQ-013 valid  output  1  addr_out is meaningful.
REQ-014 done  output  1  one-cycle pulse after the final address of a non-repeating pass is accepted.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 IDLE: valid=0, done=0, busy=0, addr_out holds its last value; start=1 at an edge SHALL load inner index=0, outer index=0, row_base=BASE, addr_out=BASE, and enter RUN.
REQ-018 Latency: addr_out=BASE with valid=1 SHALL be visible in the cycle immediately after the edge sampling start=1.
REQ-019 RUN: valid=1, busy=1; with en=0 every register SHALL hold.
REQ-020 RUN, en=1, inner index < INNER-1: inner index +1, addr_out = addr_out + STRIDE.
REQ-021 RUN, en=1, inner index = INNER-1, outer index < OUTER-1: inner index=0, outer index +1, row_base = row_base + OUTER_STRIDE, addr_out = new row_base.
REQ-022 RUN, en=1, last inner and last outer, REPEAT=0: enter DONE, valid=0 next cycle.
REQ-023 RUN, en=1, last inner and last outer, REPEAT=1: reload as on start and stay in RUN with no valid gap and no done pulse.
REQ-024 DONE: done=1, busy=1, valid=0 for exactly one cycle, then unconditionally IDLE.
REQ-025 start SHALL be ignored in RUN and DONE; start and en arriving together in IDLE SHALL only start the pass.
REQ-026 All address arithmetic SHALL be modulo 2^32, with silent wrap-around and no saturation.
REQ-027 Total accepted addresses per pass SHALL equal max(INNER,1)*max(OUTER,1); INNER=OUTER=1 SHALL give a one-address pass.

Reset
REQ-028 rst=1 SHALL immediately and asynchronously force IDLE, indices=0, row_base=0, addr_out=0, valid=0, done=0, busy=0, including mid-pass or mid-DONE.
REQ-029 After rst deasserts, the block SHALL stay in IDLE until a fresh start; no pending pass is resumed.

Verification
REQ-030 Basic 2-D: BASE=0x100, STRIDE=4, INNER=3, OUTER=2, OUTER_STRIDE=0x40, start then en=1 continuously -> addr_out 0x100,0x104,0x108,0x140,0x144,0x148 on six consecutive valid cycles, then one cycle with done=1 and valid=0, then IDLE with busy=0.
REQ-031 Stall: same config, en=0 for 3 cycles after the 2nd address -> 0x104 held for 4 cycles with valid=1, sequence otherwise unchanged, done still after the 6th acceptance.
REQ-032 Wrap: BASE=0x00000001, STRIDE=0xFFFFFFFF, INNER=3, OUTER=1 -> 0x00000001, 0x00000000, 0xFFFFFFFF, then done.
REQ-033 Repeat: REPEAT=1, BASE=0, STRIDE=1, INNER=2, OUTER=2, OUTER_STRIDE=0x10 -> 0,1,0x10,0x11,0,1,... with done never asserted; start pulses mid-run have no effect.
REQ-034 Reset mid-run: assert rst between edges while addr_out=0x104 -> outputs 0 before the next edge; after release, no valid until start, then the sequence restarts at 0x100.
REQ-035 Degenerate: INNER=0, OUTER=0, BASE=0x20 -> single address 0x20, then done pulse.

Source files
------------

// File: rtl/addr_gen.sv
// Two-level strided address generator feeding addr0 of a Mem unit.
// Inner loop steps by STRIDE, outer loop advances the row base by OUTER_STRIDE.
module addr_gen #(
    parameter logic [31:0] BASE         = 32'h0000_0000,
    parameter logic [31:0] STRIDE       = 32'h0000_0001,
    parameter int unsigned INNER        = 4,
    parameter logic [31:0] OUTER_STRIDE = 32'h0000_0000,
    parameter int unsigned OUTER        = 1,
    parameter bit          REPEAT       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        en,
    output logic [31:0] addr_out,
    output logic        valid,
    output logic        done,
    output logic        busy
);

    // A zero loop count behaves as a single iteration.
    localparam int unsigned INNER_N = (INNER == 0) ? 1 : INNER;
    localparam int unsigned OUTER_N = (OUTER == 0) ? 1 : OUTER;
    localparam logic [31:0] IN_LAST  = 32'(INNER_N - 1);
    localparam logic [31:0] OUT_LAST = 32'(OUTER_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] in_idx_q, in_idx_d;
    logic [31:0] out_idx_q, out_idx_d;
    logic [31:0] row_base_q, row_base_d;
    logic [31:0] addr_q, addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_idx_q   <= in_idx_d;
            out_idx_q  <= out_idx_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_idx_d   = in_idx_q;
        out_idx_d  = out_idx_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    in_idx_d   = '0;
                    out_idx_d  = '0;
                    row_base_d = BASE;
                    addr_d     = BASE;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    if (in_idx_q != IN_LAST) begin
                        in_idx_d = in_idx_q + 32'd1;
                        addr_d   = addr_q + STRIDE;
                    end else if (out_idx_q != OUT_LAST) begin
                        in_idx_d   = '0;
                        out_idx_d  = out_idx_q + 32'd1;
                        row_base_d = row_base_q + OUTER_STRIDE;
                        addr_d     = row_base_q + OUTER_STRIDE;
                    end else if (REPEAT) begin
                        // Reload in place so the stream continues without a valid gap.
                        in_idx_d   = '0;
                        out_idx_d  = '0;
                        row_base_d = BASE;
                        addr_d     = BASE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign addr_out = addr_q;
    assign valid    = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench: several addr_gen configurations compared against a
// nested-loop address list model under fixed and random consumer stalls.
module tb_addr_gen;

    localparam int NI = 5;
    // 0 basic 2-D, 1 wrap, 2 repeat, 3 degenerate, 4 negative row stride with wrap
    localparam logic [31:0] P_BASE [NI] = '{32'h100, 32'h1, 32'h0, 32'h20, 32'hFFFF_FFF0};
    localparam logic [31:0] P_ST   [NI] = '{32'h4, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h8};
    localparam int unsigned P_IN   [NI] = '{3, 3, 2, 0, 5};
    localparam logic [31:0] P_OS   [NI] = '{32'h40, 32'h0, 32'h10, 32'h0, 32'hFFFF_FF00};
    localparam int unsigned P_OUT  [NI] = '{2, 1, 2, 0, 3};
    localparam bit          P_REP  [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [NI];
    logic        en_s    [NI];
    logic [31:0] addr_s  [NI];
    logic        valid_s [NI];
    logic        done_s  [NI];
    logic        busy_s  [NI];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    addr_gen #(.BASE(P_BASE[0]), .STRIDE(P_ST[0]), .INNER(P_IN[0]), .OUTER_STRIDE(P_OS[0]),
               .OUTER(P_OUT[0]), .REPEAT(P_REP[0])) u_basic (
        .clk(clk), .rst(rst), .start(start_s[0]), .en(en_s[0]),
        .addr_out(addr_s[0]), .valid(valid_s[0]), .done(done_s[0]), .busy(busy_s[0]));
    addr_gen #(.BASE(P_BASE[1]), .STRIDE(P_ST[1]), .INNER(P_IN[1]), .OUTER_STRIDE(P_OS[1]),
               .OUTER(P_OUT[1]), .REPEAT(P_REP[1])) u_wrap (
        .clk(clk), .rst(rst), .start(start_s[1]), .en(en_s[1]),
        .addr_out(addr_s[1]), .valid(valid_s[1]), .done(done_s[1]), .busy(busy_s[1]));
    addr_gen #(.BASE(P_BASE[2]), .STRIDE(P_ST[2]), .INNER(P_IN[2]), .OUTER_STRIDE(P_OS[2]),
               .OUTER(P_OUT[2]), .REPEAT(P_REP[2])) u_rep (
        .clk(clk), .rst(rst), .start(start_s[2]), .en(en_s[2]),
        .addr_out(addr_s[2]), .valid(valid_s[2]), .done(done_s[2]), .busy(busy_s[2]));
    addr_gen #(.BASE(P_BASE[3]), .STRIDE(P_ST[3]), .INNER(P_IN[3]), .OUTER_STRIDE(P_OS[3]),
               .OUTER(P_OUT[3]), .REPEAT(P_REP[3])) u_degen (
        .clk(clk), .rst(rst), .start(start_s[3]), .en(en_s[3]),
        .addr_out(addr_s[3]), .valid(valid_s[3]), .done(done_s[3]), .busy(busy_s[3]));
    addr_gen #(.BASE(P_BASE[4]), .STRIDE(P_ST[4]), .INNER(P_IN[4]), .OUTER_STRIDE(P_OS[4]),
               .OUTER(P_OUT[4]), .REPEAT(P_REP[4])) u_neg (
        .clk(clk), .rst(rst), .start(start_s[4]), .en(en_s[4]),
        .addr_out(addr_s[4]), .valid(valid_s[4]), .done(done_s[4]), .busy(busy_s[4]));

    // Reference: every address of one pass, outer-major, plain modular arithmetic.
    task automatic build_exp(input int k);
        int unsigned ni, no;
        exp_q.delete();
        ni = (P_IN[k] == 0) ? 1 : P_IN[k];
        no = (P_OUT[k] == 0) ? 1 : P_OUT[k];
        for (int unsigned o = 0; o < no; o++)
            for (int unsigned i = 0; i < ni; i++)
                exp_q.push_back(P_BASE[k] + 32'(o) * P_OS[k] + 32'(i) * P_ST[k]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: en always 1; mode 1: random en; mode 2: three stall cycles on 2nd address
    task automatic run_pass(input int k, input int mode, input string name);
        int idx = 0, cyc = 0, stall = 0, n;
        logic e;
        build_exp(k);
        n = exp_q.size();
        start_s[k] = 1'b1;
        en_s[k] = 1'($urandom_range(0, 1));
        step();
        start_s[k] = 1'b0;
        while (idx < n && cyc < 300) begin
            checks++;
            if ({valid_s[k], busy_s[k], done_s[k]} !== 3'b110) begin
                errors++;
                $display("FAIL %s run_flags idx=%0d got vbd=%b%b%b want 110", name, idx,
                         valid_s[k], busy_s[k], done_s[k]);
            end
            checks++;
            if (addr_s[k] !== exp_q[idx]) begin
                errors++;
                $display("FAIL %s addr idx=%0d got %h want %h", name, idx, addr_s[k], exp_q[idx]);
            end
            case (mode)
                0: e = 1'b1;
                1: e = 1'($urandom_range(0, 1));
                default: begin
                    e = !(idx == 1 && stall < 3);
                    if (!e) stall++;
                end
            endcase
            en_s[k] = e;
            step();
            if (e) idx++;
            cyc++;
        end
        checks++;
        if (idx < n) begin
            errors++;
            $display("FAIL %s timeout accepted=%0d want %0d", name, idx, n);
        end
        // start during DONE must be ignored
        start_s[k] = 1'b1;
        en_s[k] = 1'($urandom_range(0, 1));
        checks++;
        if ({valid_s[k], busy_s[k], done_s[k]} !== 3'b011) begin
            errors++;
            $display("FAIL %s done_flags got vbd=%b%b%b want 011", name,
                     valid_s[k], busy_s[k], done_s[k]);
        end
        step();
        start_s[k] = 1'b0;
        en_s[k] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({valid_s[k], busy_s[k], done_s[k]} !== 3'b000 || addr_s[k] !== exp_q[n-1]) begin
                errors++;
                $display("FAIL %s idle c=%0d got vbd=%b%b%b addr=%h want 000 addr=%h", name, c,
                         valid_s[k], busy_s[k], done_s[k], addr_s[k], exp_q[n-1]);
            end
            step();
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({valid_s[k], busy_s[k], done_s[k]} !== 3'b000 || addr_s[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got vbd=%b%b%b addr=%h want 000 addr=0", k,
                         valid_s[k], busy_s[k], done_s[k], addr_s[k]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        start_s[0] = 1'b1;
        en_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        checks++;
        if (addr_s[0] !== 32'h104 || valid_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got addr=%h v=%b want 104 v=1", addr_s[0], valid_s[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid_s[0], busy_s[0], done_s[0]} !== 3'b000 || addr_s[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_async got vbd=%b%b%b addr=%h want 000 addr=0",
                     valid_s[0], busy_s[0], done_s[0], addr_s[0]);
        end
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_resume c=%0d got v=%b b=%b want 0 0", c, valid_s[0], busy_s[0]);
            end
        end
        en_s[0] = 1'b0;
        run_pass(0, 0, "rst_restart");
    endtask

    task automatic test_repeat();
        int idx = 0, n, acc = 0, cyc = 0;
        logic e;
        build_exp(2);
        n = exp_q.size();
        start_s[2] = 1'b1;
        step();
        start_s[2] = 1'b0;
        while (acc < 3 * n + 2 && cyc < 300) begin
            checks++;
            if ({valid_s[2], busy_s[2], done_s[2]} !== 3'b110 || addr_s[2] !== exp_q[idx]) begin
                errors++;
                $display("FAIL repeat acc=%0d got vbd=%b%b%b addr=%h want 110 addr=%h", acc,
                         valid_s[2], busy_s[2], done_s[2], addr_s[2], exp_q[idx]);
            end
            e = 1'($urandom_range(0, 1));
            en_s[2] = e;
            start_s[2] = 1'($urandom_range(0, 1));
            step();
            if (e) begin
                idx = (idx + 1) % n;
                acc++;
            end
            cyc++;
        end
        checks++;
        if (acc < 3 * n + 2) begin
            errors++;
            $display("FAIL repeat timeout accepted=%0d want %0d", acc, 3 * n + 2);
        end
        start_s[2] = 1'b0;
        en_s[2] = 1'b0;
    endtask

    task automatic test_basic();      run_pass(0, 0, "basic");      endtask
    task automatic test_stall();      run_pass(0, 2, "stall");      endtask
    task automatic test_random_en();
        for (int r = 0; r < 3; r++) run_pass(0, 1, "rand_basic");
        for (int r = 0; r < 3; r++) run_pass(4, 1, "rand_negstride");
    endtask
    task automatic test_wrap();       run_pass(1, 1, "wrap");       endtask
    task automatic test_degenerate(); run_pass(3, 1, "degenerate"); endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            start_s[k] = 1'b0;
            en_s[k] = 1'b0;
        end
        #12;
        test_reset();
        rst = 1'b0;
        step();
        test_basic();
        test_stall();
        test_wrap();
        test_degenerate();
        test_random_en();
        test_reset_midrun();
        test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
